// File: rtl/izneuron_sweep_scheduler.sv
// Izhikevich sweep scheduler: walks every neuron through the shared update core once per tick,
// builds the population raster and queues spiking neuron indices in a small FWFT event FIFO.
module izneuron_sweep_scheduler #(
  parameter int unsigned N_NEURONS  = 128,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_start,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic                 first_pass,
  input  logic                 fired,
  output logic                 busy,
  output logic                 sweep_done,
  output logic [N_NEURONS-1:0] population,
  output logic [ADDR_W:0]      spike_count,
  output logic                 evt_valid,
  output logic [ADDR_W-1:0]    evt_addr,
  input  logic                 evt_ready,
  output logic                 evt_drop,
  output logic                 tick_overrun
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_NEURONS - 1);
  localparam logic [OCC_W-1:0]  FULL_OCC  = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;

  // Read-to-writeback delay line matching the core latency
  logic [RD_LAT-1:0] pipe_v;
  logic [ADDR_W-1:0] pipe_a [RD_LAT];

  assign wr_en   = pipe_v[RD_LAT-1];
  assign wr_addr = pipe_a[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_a[i] <= '0;
    end else begin
      pipe_v[0] <= rd_en;
      pipe_a[0] <= rd_addr;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  // Raster accumulator including the write-back of the current cycle
  logic [N_NEURONS-1:0] acc;
  logic [N_NEURONS-1:0] acc_next;

  always_comb begin
    acc_next = acc;
    if (wr_en) acc_next[wr_addr] = fired;
  end

  function automatic logic [CNT_W-1:0] popcount(input logic [N_NEURONS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_NEURONS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Sweep sequencer; population/spike_count become visible together with sweep_done
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      busy         <= 1'b0;
      sweep_done   <= 1'b0;
      first_pass   <= 1'b1;
      population   <= '0;
      spike_count  <= '0;
      tick_overrun <= 1'b0;
      acc          <= '0;
    end else begin
      sweep_done <= 1'b0;
      acc        <= acc_next;
      if (tick_start && state != S_IDLE) tick_overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (tick_start) begin
            state   <= S_ISSUE;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            busy    <= 1'b1;
            acc     <= '0;
          end
        end
        S_ISSUE: begin
          if (rd_addr == LAST_ADDR) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (wr_en && wr_addr == LAST_ADDR) begin
            state       <= S_DONE;
            sweep_done  <= 1'b1;
            population  <= acc_next;
            spike_count <= popcount(acc_next);
            first_pass  <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Spike event FIFO, first-word-fall-through
  logic [ADDR_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_next;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              full;

  always_comb begin
    push_req = wr_en & fired;
    full     = (occ == FULL_OCC);
    pop      = evt_valid & evt_ready;
    push_ok  = push_req & (~full | pop);
    occ_next = occ;
    case ({push_ok, pop})
      2'b10:   occ_next = occ + OCC_W'(1);
      2'b01:   occ_next = occ - OCC_W'(1);
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      evt_valid <= 1'b0;
      evt_drop  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      occ       <= occ_next;
      evt_valid <= (occ_next != '0);
      if (push_req && full && !pop) evt_drop <= 1'b1;
    end
  end

  assign evt_addr = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_izneuron_sweep_scheduler.sv
// Directed bench for izneuron_sweep_scheduler: sweep timing, raster, event FIFO, overrun,
// mid-sweep reset, and a second instance with a three-cycle core latency.
module tb_izneuron_sweep_scheduler;

  localparam int unsigned N  = 128;
  localparam int unsigned AW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick_start = 1'b0;
  logic          rd_en, wr_en, first_pass, busy, sweep_done;
  logic [AW-1:0] rd_addr, wr_addr, evt_addr;
  logic          fired;
  logic [N-1:0]  population;
  logic [AW:0]   spike_count;
  logic          evt_valid, evt_drop, tick_overrun;
  logic          evt_ready = 1'b1;
  logic [N-1:0]  fire_mask = '0;

  logic          tick3 = 1'b0;
  logic          rd_en3, wr_en3, first_pass3, busy3, sweep_done3;
  logic [AW-1:0] rd_addr3, wr_addr3, evt_addr3;
  logic          fired3 = 1'b0;
  logic [N-1:0]  population3;
  logic [AW:0]   spike_count3;
  logic          evt_valid3, evt_drop3, tick_overrun3;
  logic          evt_ready3 = 1'b1;

  int total = 0;
  int bad = 0;
  logic [AW-1:0] evq [$];

  always #5 clk = ~clk;

  assign fired = fire_mask[wr_addr];

  izneuron_sweep_scheduler #(.N_NEURONS(N), .ADDR_W(AW), .RD_LAT(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .tick_start(tick_start),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .first_pass(first_pass), .fired(fired), .busy(busy), .sweep_done(sweep_done),
    .population(population), .spike_count(spike_count),
    .evt_valid(evt_valid), .evt_addr(evt_addr), .evt_ready(evt_ready),
    .evt_drop(evt_drop), .tick_overrun(tick_overrun)
  );

  izneuron_sweep_scheduler #(.N_NEURONS(N), .ADDR_W(AW), .RD_LAT(3), .FIFO_DEPTH(16)) dut3 (
    .clk(clk), .reset(reset), .tick_start(tick3),
    .rd_en(rd_en3), .rd_addr(rd_addr3), .wr_en(wr_en3), .wr_addr(wr_addr3),
    .first_pass(first_pass3), .fired(fired3), .busy(busy3), .sweep_done(sweep_done3),
    .population(population3), .spike_count(spike_count3),
    .evt_valid(evt_valid3), .evt_addr(evt_addr3), .evt_ready(evt_ready3),
    .evt_drop(evt_drop3), .tick_overrun(tick_overrun3)
  );

  // Accepted events; handshake completes on the following rising edge
  always @(negedge clk) begin
    if (evt_valid && evt_ready) evq.push_back(evt_addr);
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse tick_start and return in the sweep_done cycle; done_cyc counts cycles from the tick
  task automatic run_sweep(output int done_cyc);
    tick_start = 1'b1;
    step();
    tick_start = 1'b0;
    done_cyc = 0;
    for (int k = 1; k < 400; k++) begin
      if (sweep_done) begin
        done_cyc = k;
        break;
      end
      step();
    end
  endtask

  initial begin
    int dc;
    logic [N-1:0] exp_pop;

    // Reset values
    step(); step(); step();
    reset = 1'b0;
    check("rst_rd_en", N'(rd_en), N'(0));
    check("rst_wr_en", N'(wr_en), N'(0));
    check("rst_rd_addr", N'(rd_addr), N'(0));
    check("rst_wr_addr", N'(wr_addr), N'(0));
    check("rst_first_pass", N'(first_pass), N'(1));
    check("rst_busy", N'(busy), N'(0));
    check("rst_done", N'(sweep_done), N'(0));
    check("rst_pop", population, '0);
    check("rst_cnt", N'(spike_count), N'(0));
    check("rst_evt_valid", N'(evt_valid), N'(0));
    check("rst_evt_addr", N'(evt_addr), N'(0));
    check("rst_drop", N'(evt_drop), N'(0));
    check("rst_overrun", N'(tick_overrun), N'(0));

    // Sweep 1: no spikes, full cycle-by-cycle timing
    evq.delete();
    tick_start = 1'b1;
    step();
    tick_start = 1'b0;
    for (int k = 1; k <= 131; k++) begin
      check("t1_rd_en", N'(rd_en), N'(k <= 128));
      if (k <= 128) check("t1_rd_addr", N'(rd_addr), N'(k - 1));
      check("t1_wr_en", N'(wr_en), N'(k >= 2 && k <= 129));
      if (k >= 2 && k <= 129) check("t1_wr_addr", N'(wr_addr), N'(k - 2));
      check("t1_done", N'(sweep_done), N'(k == 130));
      check("t1_busy", N'(busy), N'(k <= 130));
      check("t1_first_pass", N'(first_pass), N'(k < 130));
      step();
    end
    check("t1_pop", population, '0);
    check("t1_cnt", N'(spike_count), N'(0));
    check("t1_evq", N'(evq.size()), N'(0));

    // Sweep 2: spikes at 3, 64, 127 delivered in order
    fire_mask = '0;
    fire_mask[3] = 1'b1;
    fire_mask[64] = 1'b1;
    fire_mask[127] = 1'b1;
    exp_pop = fire_mask;
    evq.delete();
    run_sweep(dc);
    check("t2_done_cyc", N'(dc), N'(130));
    check("t2_pop", population, exp_pop);
    check("t2_cnt", N'(spike_count), N'(3));
    check("t2_first_pass", N'(first_pass), N'(0));
    for (int i = 0; i < 5; i++) step();
    check("t2_evq_n", N'(evq.size()), N'(3));
    if (evq.size() == 3) begin
      check("t2_evt0", N'(evq[0]), N'(3));
      check("t2_evt1", N'(evq[1]), N'(64));
      check("t2_evt2", N'(evq[2]), N'(127));
    end
    check("t2_drop", N'(evt_drop), N'(0));

    // Sweep 3: every neuron fires with consumer stalled
    fire_mask = '1;
    evt_ready = 1'b0;
    evq.delete();
    run_sweep(dc);
    check("t3_done_cyc", N'(dc), N'(130));
    check("t3_cnt", N'(spike_count), N'(128));
    check("t3_pop", population, '1);
    check("t3_drop", N'(evt_drop), N'(1));
    check("t3_evt_valid", N'(evt_valid), N'(1));
    check("t3_head", N'(evt_addr), N'(0));
    evt_ready = 1'b1;
    for (int i = 0; i < 25; i++) step();
    check("t3_evq_n", N'(evq.size()), N'(16));
    for (int i = 0; i < 16; i++) begin
      if (i < evq.size()) check("t3_evt", N'(evq[i]), N'(i));
    end
    check("t3_evt_empty", N'(evt_valid), N'(0));

    // Sweep 4: tick during sweep is ignored and flagged
    fire_mask = '0;
    tick_start = 1'b1;
    step();
    for (int k = 1; k <= 135; k++) begin
      tick_start = (k == 50);
      check("t4_done", N'(sweep_done), N'(k == 130));
      check("t4_busy", N'(busy), N'(k <= 130));
      step();
    end
    tick_start = 1'b0;
    check("t4_overrun", N'(tick_overrun), N'(1));
    check("t4_rd_en", N'(rd_en), N'(0));

    // Sweep 5: reset at cycle 40 aborts the sweep
    tick_start = 1'b1;
    step();
    tick_start = 1'b0;
    for (int k = 1; k < 40; k++) step();
    check("t5_pre_busy", N'(busy), N'(1));
    reset = 1'b1;
    step();
    check("t5_rd_en", N'(rd_en), N'(0));
    check("t5_wr_en", N'(wr_en), N'(0));
    check("t5_busy", N'(busy), N'(0));
    check("t5_first_pass", N'(first_pass), N'(1));
    check("t5_evt_valid", N'(evt_valid), N'(0));
    check("t5_overrun", N'(tick_overrun), N'(0));
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_no_wr", N'(wr_en), N'(0));
    end
    fire_mask = '0;
    fire_mask[5] = 1'b1;
    exp_pop = fire_mask;
    evq.delete();
    run_sweep(dc);
    check("t5_done_cyc", N'(dc), N'(130));
    check("t5_pop", population, exp_pop);
    check("t5_cnt", N'(spike_count), N'(1));
    check("t5_first_pass", N'(first_pass), N'(0));
    step(); step(); step();
    check("t5_evq_n", N'(evq.size()), N'(1));

    // RD_LAT=3 instance timing
    tick3 = 1'b1;
    step();
    tick3 = 1'b0;
    for (int k = 1; k <= 133; k++) begin
      check("t6_rd_en", N'(rd_en3), N'(k <= 128));
      if (k <= 128) check("t6_rd_addr", N'(rd_addr3), N'(k - 1));
      check("t6_wr_en", N'(wr_en3), N'(k >= 4 && k <= 131));
      if (k >= 4 && k <= 131) check("t6_wr_addr", N'(wr_addr3), N'(k - 4));
      check("t6_done", N'(sweep_done3), N'(k == 132));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/izneuron_sweep_scheduler.md
Name: izneuron_sweep_scheduler

Overview:
Sequences the shared, time-multiplexed Izhikevich update datapath across all neurons once per simulation tick. It issues one read/compute/write slot per neuron, pipelined to one neuron per clock. It collects the datapath's fired flags into a population raster and pushes spiking neuron indices into a small event FIFO. It sits between the tick generator and the u/v state RAMs plus compute core; it replaces the fixed two-phase index counter.

Parameters:
N_NEURONS, 128, neurons per sweep (2..2^ADDR_W)
ADDR_W, 7, neuron index width
RD_LAT, 1, cycles from rd_en/rd_addr to fired valid at the core output (1..4)
FIFO_DEPTH, 16, spike event FIFO entries (power of 2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
tick_start  in  1  one-cycle pulse that starts a sweep
rd_en  out  1  read strobe to u/v RAMs
rd_addr  out  ADDR_W  neuron index being read
wr_en  out  1  write-back strobe to u/v RAMs
wr_addr  out  ADDR_W  neuron index being written
first_pass  out  1  core selects u_init/v_init instead of RAM data
fired  in  1  core spike flag for neuron wr_addr, sampled when wr_en=1
busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse after last write-back
population  out  N_NEURONS  raster of last completed sweep, bit k = neuron k
spike_count  out  ADDR_W+1  number of spikes in last completed sweep
evt_valid  out  1  spike event available
evt_addr  out  ADDR_W  index of spiking neuron
evt_ready  in  1  consumer accepts event when evt_valid & evt_ready
evt_drop  out  1  sticky: event lost to full FIFO
tick_overrun  out  1  sticky: tick_start seen while busy

Behaviour:
- Reset values: rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, first_pass=1, busy=0, sweep_done=0, population=0, spike_count=0, evt_valid=0, evt_addr=0, evt_drop=0, tick_overrun=0. FIFO is emptied, the raster accumulator is cleared, and the in-flight pipeline is cancelled (no wr_en follows a reset).
- FSM states:
  - IDLE: on tick_start, go to ISSUE, busy=1, rd_addr=0.
  - ISSUE: rd_en=1 each cycle; rd_addr increments 0..N_NEURONS-1. After issuing index N_NEURONS-1, go to DRAIN.
  - DRAIN: rd_en=0; wait until the last write-back completes, then go to DONE.
  - DONE: one cycle; sweep_done=1, population/spike_count updated, return to IDLE with busy=0.
- Write-back pipeline: a read issued at cycle t produces wr_en=1 and wr_addr=that index at cycle t+RD_LAT, implemented as a shift register of (valid, addr). Exactly N_NEURONS writes occur per sweep, in index order, one per cycle.
- Latency: tick_start at cycle 0 -> first rd_en at cycle 1 -> last wr_en at cycle N_NEURONS+RD_LAT -> sweep_done at cycle N_NEURONS+RD_LAT+1.
- Raster: when wr_en=1, accumulator bit wr_addr <= fired. In DONE, population <= accumulator with the final bit included, and spike_count <= popcount. The accumulator is cleared at sweep start.
- first_pass: 1 from reset through the end of the first sweep; it clears in the DONE cycle of the first sweep and stays 0 until the next reset.
- FIFO push: on wr_en & fired, write wr_addr. If the FIFO is full and no pop occurs in the same cycle, the event is dropped and evt_drop is set (sticky until reset). Simultaneous push and pop when full is allowed and nothing is lost.
- FIFO pop: on evt_valid & evt_ready. The FIFO is first-word-fall-through: evt_addr is valid whenever evt_valid=1 and stays stable until accepted.
- tick_start while busy (or in DONE): ignored, tick_overrun set (sticky). tick_start in IDLE in the same cycle as reset: reset wins.
- Pointer counters wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.

Test Plan:
- Reset then tick_start with fired tied 0 (N=128, RD_LAT=1) -> rd_en high for cycles 1..128, wr_en for cycles 2..129 with wr_addr 0..127, sweep_done at cycle 130, population=0, spike_count=0, first_pass drops at cycle 130.
- fired=1 only when wr_addr ∈ {3,64,127}, evt_ready=1 -> population bits 3, 64, 127 set, spike_count=3, events 3, 64, 127 delivered in order, evt_drop=0.
- fired=1 for all neurons, evt_ready=0 (FIFO_DEPTH=16) -> FIFO holds 0..15, evt_drop=1, spike_count=128; then assert evt_ready -> exactly 16 events, addresses 0..15.
- tick_start pulsed at cycle 50 of a sweep -> sweep unaffected, tick_overrun=1, no second sweep starts.
- reset asserted at cycle 40 of a sweep -> next cycle: rd_en=0, wr_en=0, busy=0, first_pass=1, evt_valid=0; a fresh tick_start then completes a normal sweep.
- RD_LAT=3 -> wr_addr k appears 3 cycles after rd_addr k; sweep_done at cycle N_NEURONS+4 after tick_start.
